// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule types, S-box table and GF(2^8) helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Entry 0 sits in the most-significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_subword.sv
// ============================================================================
// Module      : aes_subword
// Description : Combinational AES SubWord, four parallel S-box lookups.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128/192/256 key schedule, one word per cycle,
//               round keys delivered over a valid/ready handshake.
//               Optional macro AES_KEY_ZEROIZE_EN clears key material on done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [3:0]      rk_round,
  output logic [31:0]     k0_out,
  output logic [31:0]     k1_out,
  output logic [31:0]     k2_out,
  output logic [31:0]     k3_out,
  output logic            done
);

  localparam int NR = nr_from_nk(NK);
  localparam int NW = 4 * (NR + 1);

  state_t            r_state;
  logic [32*NK-1:0]  r_win;
  logic [95:0]       r_asm;
  logic [5:0]        r_idx;
  logic [2:0]        r_mod;
  logic [3:0]        r_grp;
  logic [7:0]        r_rcon;

  logic [31:0] w_old, w_prev, w_sub_in, w_sub_out, w_temp, w_new;
  logic        w_copy, w_use_rcon, w_fourth, w_stall, w_adv;

  // Window MSB word is w[i-NK], LSB word is w[i-1]; during the copy phase the
  // captured key simply rotates through, so w_old is also w[i] for i < NK.
  assign w_old      = r_win[32*NK-1 -: 32];
  assign w_prev     = r_win[31:0];
  assign w_copy     = (r_idx < 6'(NK));
  assign w_use_rcon = !w_copy && (r_mod == 3'd0);
  assign w_sub_in   = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (w_use_rcon)
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_mod == 3'd4)
      w_temp = w_sub_out;
  end

  assign w_new    = w_copy ? w_old : (w_old ^ w_temp);
  assign w_fourth = (r_idx[1:0] == 2'd3);
  assign w_stall  = w_fourth && rk_valid && !rk_ready;
  assign w_adv    = (r_state == GEN) && !w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_win    <= '0;
      r_asm    <= '0;
      r_idx    <= '0;
      r_mod    <= '0;
      r_grp    <= '0;
      r_rcon   <= RCON_INIT;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_round <= '0;
      k0_out   <= '0;
      k1_out   <= '0;
      k2_out   <= '0;
      k3_out   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // A load later in this block overrides the clear for back-to-back keys.
      if (rk_valid && rk_ready)
        rk_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_win   <= key_in;
            r_idx   <= '0;
            r_mod   <= '0;
            r_grp   <= '0;
            r_rcon  <= RCON_INIT;
            busy    <= 1'b1;
            r_state <= GEN;
          end
        end

        GEN: begin
          if (w_adv) begin
            r_win <= {r_win[32*NK-33:0], w_new};
            r_idx <= r_idx + 6'd1;
            r_mod <= (r_mod == 3'(NK-1)) ? 3'd0 : r_mod + 3'd1;
            if (w_use_rcon)
              r_rcon <= xtime(r_rcon);
            if (w_fourth) begin
              k0_out   <= r_asm[95:64];
              k1_out   <= r_asm[63:32];
              k2_out   <= r_asm[31:0];
              k3_out   <= w_new;
              rk_valid <= 1'b1;
              rk_round <= r_grp;
              r_grp    <= r_grp + 4'd1;
            end else begin
              r_asm <= {r_asm[63:0], w_new};
            end
            if (r_idx == 6'(NW-1))
              r_state <= DRAIN;
          end
        end

        DRAIN: begin
          if (rk_valid && rk_ready) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= IDLE;
`ifdef AES_KEY_ZEROIZE_EN
            r_win  <= '0;
            r_asm  <= '0;
            k0_out <= '0;
            k1_out <= '0;
            k2_out <= '0;
            k3_out <= '0;
`endif
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand.sv
// ============================================================================
// Module      : tb_aes_key_expand
// Description : Self-checking bench for aes_key_expand at NK = 4, 6 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [2:0]           start, rk_ready, busy, rk_valid, done;
  logic [2:0][255:0]    key;
  logic [2:0][3:0]      rk_round;
  logic [2:0][31:0]     k0, k1, k2, k3;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NKG = 4 + 2 * g;
    aes_key_expand #(.NK(NKG)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .key_in   (key[g][255 -: 32*NKG]),
      .busy     (busy[g]),
      .rk_valid (rk_valid[g]),
      .rk_ready (rk_ready[g]),
      .rk_round (rk_round[g]),
      .k0_out   (k0[g]),
      .k1_out   (k1[g]),
      .k2_out   (k2[g]),
      .k3_out   (k3[g]),
      .done     (done[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // S-box derived from its definition: GF(2^8) inverse then affine map.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, t;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      s = inv; t = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sb[v] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  logic [31:0] mw  [60];
  logic [31:0] cap [60];

  task automatic build_model(input int nk, input logic [255:0] kk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = kk[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mround(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // mode 0: always ready, 1: ten-cycle stall at round 3, 2: random ready
  task automatic run(input int g, input logic [255:0] kk, input int mode, input string tag);
    int nk, nr, cyc, stall_n, first_v, acc;
    bit hold, rdy, fin;
    logic [127:0] cur, prev_k, last_k;
    logic [3:0]   prev_r;
    nk = 4 + 2*g; nr = nk + 6;
    build_model(nk, kk);
    key[g] = kk;
    acc = 0; stall_n = 0; first_v = -1; hold = 0; fin = 0; cyc = 0;
    prev_k = '0; prev_r = '0;
    @(negedge clk); start[g] = 1'b1; rk_ready[g] = 1'b0;
    @(posedge clk);
    @(negedge clk); start[g] = 1'b0;
    chk({tag, " busy"}, busy[g], 1);
    while (!fin && cyc < 400) begin
      cur = {k0[g], k1[g], k2[g], k3[g]};
      if (hold) begin
        chk({tag, " stall key"}, cur, prev_k);
        chk({tag, " stall round"}, rk_round[g], prev_r);
        chk({tag, " stall valid"}, rk_valid[g], 1);
      end
      if (done[g]) begin
        fin = 1;
      end else begin
        if (rk_valid[g] && first_v < 0) first_v = cyc;
        case (mode)
          1:       rdy = !(rk_valid[g] && rk_round[g] == 4'd3 && stall_n < 10);
          2:       rdy = ($urandom_range(0, 3) != 0);
          default: rdy = 1'b1;
        endcase
        if (mode == 1 && !rdy) stall_n++;
        rk_ready[g] = rdy;
        if (rk_valid[g] && rdy) begin
          chk({tag, " round idx"}, rk_round[g], acc);
          if (acc <= nr) begin
            chk({tag, " round key"}, cur, mround(acc));
            for (int j = 0; j < 4; j++) cap[4*acc+j] = cur[127 - 32*j -: 32];
          end
          acc++;
        end
        hold   = rk_valid[g] && !rdy;
        prev_k = cur;
        prev_r = rk_round[g];
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    rk_ready[g] = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout: actual=no done required=done", tag);
    end else begin
      chk({tag, " rounds accepted"}, acc, nr + 1);
      chk({tag, " busy at done"}, busy[g], 0);
      chk({tag, " valid at done"}, rk_valid[g], 0);
      if (mode == 0) begin
        chk({tag, " first valid cycle"}, first_v, 4);
        chk({tag, " done cycle"}, cyc, 4*(nr+1) + 1);
      end
      if (mode == 1) chk({tag, " done cycle"}, cyc, 4*(nr+1) + 8);
`ifdef AES_KEY_ZEROIZE_EN
      last_k = '0;
`else
      last_k = mround(nr);
`endif
      chk({tag, " key at done"}, {k0[g], k1[g], k2[g], k3[g]}, last_k);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " done pulse"}, done[g], 0);
      chk({tag, " key after done"}, {k0[g], k1[g], k2[g], k3[g]}, last_k);
    end
  endtask

  typedef struct {
    int          g;
    int          widx;
    logic [31:0] w;
  } kat_t;

  kat_t kat [21];

  task automatic apply_kat(input int g);
    for (int i = 0; i < 21; i++)
      if (kat[i].g == g) chk($sformatf("kat nk%0d w%0d", 4 + 2*g, kat[i].widx), cap[kat[i].widx], kat[i].w);
  endtask

  task automatic zero_outputs(input int g, input string tag);
    chk({tag, " busy"}, busy[g], 0);
    chk({tag, " rk_valid"}, rk_valid[g], 0);
    chk({tag, " rk_round"}, rk_round[g], 0);
    chk({tag, " keys"}, {k0[g], k1[g], k2[g], k3[g]}, 0);
    chk({tag, " done"}, done[g], 0);
  endtask

  localparam logic [255:0] KEY4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] rk;
    int acc, cyc;
    bit pulsed, seen5;

    kat = '{
      '{0, 0,  32'h2b7e1516}, '{0, 3,  32'h09cf4f3c},
      '{0, 4,  32'ha0fafe17}, '{0, 5,  32'h88542cb1}, '{0, 6,  32'h23a33939}, '{0, 7,  32'h2a6c7605},
      '{0, 40, 32'hd014f9a8}, '{0, 41, 32'hc9ee2589}, '{0, 42, 32'he13f0cc8}, '{0, 43, 32'hb6630ca6},
      '{1, 6,  32'hfe0c91f7},
      '{1, 48, 32'he98ba06f}, '{1, 49, 32'h448c773c}, '{1, 50, 32'h8ecc7204}, '{1, 51, 32'h01002202},
      '{2, 8,  32'h9ba35411}, '{2, 9,  32'h8e6925af}, '{2, 10, 32'ha51a8b5f}, '{2, 11, 32'h2067fcde},
      '{2, 56, 32'hfe4890d1}, '{2, 59, 32'h706c631e}
    };

    build_sbox();
    reset = 1'b1; start = '0; rk_ready = '0; key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int g = 0; g < 3; g++) zero_outputs(g, $sformatf("reset nk%0d", 4 + 2*g));

    run(0, KEY4, 0, "nk4 fips");  apply_kat(0);
    run(1, KEY6, 0, "nk6 fips");  apply_kat(1);
    run(2, KEY8, 0, "nk8 fips");  apply_kat(2);
    run(0, KEY4, 1, "nk4 stall"); apply_kat(0);

    for (int g = 0; g < 3; g++)
      for (int n = 0; n < 2; n++) begin
        for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
        run(g, rk, 2, $sformatf("rand nk%0d #%0d", 4 + 2*g, n));
      end

    // Reset abort at round 5 with a start pulse while busy.
    build_model(4, KEY4);
    key[0] = KEY4; acc = 0; pulsed = 0; seen5 = 0; cyc = 0;
    @(negedge clk); start[0] = 1'b1; rk_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[0] = 1'b0;
    while (!seen5 && cyc < 200) begin
      start[0] = 1'b0;
      if (rk_valid[0] && rk_round[0] == 4'd5) begin
        seen5 = 1;
        chk("abort round5 key", {k0[0], k1[0], k2[0], k3[0]}, mround(5));
      end else begin
        if (rk_valid[0]) begin
          chk("abort round idx", rk_round[0], acc);
          acc++;
        end
        if (rk_valid[0] && rk_round[0] == 4'd2 && !pulsed) begin
          start[0] = 1'b1;
          pulsed = 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen5) begin
      checks++; errors++;
      $display("FAIL abort timeout: actual=no round5 required=round5");
    end
    chk("abort busy before reset", busy[0], 1);
    reset = 1'b1; rk_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    zero_outputs(0, "after abort");
    @(posedge clk);
    @(negedge clk);
    zero_outputs(0, "idle after abort");
    run(0, KEY8, 0, "fresh after abort");
    chk("fresh round0 = key", {cap[0], cap[1], cap[2], cap[3]}, KEY8[255:128]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
